// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Stall and flush sequencer for the 4-stage pipeline (IF, ID, EXE, LSU/WB).
// It handles the hazards that forwarding cannot cover: load-use, branch
// mispredict, data-memory wait and instruction-fetch wait. From these it
// drives the per-stage register enables and the NOP-insertion controls. It
// also keeps two saturating performance counters.
//
// Parameters
//   LOAD_LAT      data-memory read latency; a load-use hazard holds ID for
//                 this many cycles (1..8)
//   FLUSH_CYCLES  cycles IF/ID is killed after a mispredict (1..8)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1_addr/id_rs2_addr   source registers of the ID instruction
//   id_rs1_used/id_rs2_used   ID instruction actually reads rs1/rs2
//   exe_wr_addr, exe_reg_wr   destination and write flag of the EXE instr
//   exe_is_load               EXE instruction is a load
//   br_mispredict             EXE branch resolved against the prediction
//   lsu_req, lsu_ack          outstanding data access / completes this cycle
//   imem_ready                instruction fetch data valid this cycle
//   pc_en, ifid_en, idexe_en, exelsu_en   pipeline register enables
//   ifid_flush, idexe_flush   load a NOP into IF/ID or ID/EXE
//   ctrl_state                RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3
//   stall_count               cycles with pc_en low (saturating)
//   flush_count               accepted mispredicts (saturating)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  exe_wr_addr,
  input  logic        exe_reg_wr,
  input  logic        exe_is_load,
  input  logic        br_mispredict,
  input  logic        lsu_req,
  input  logic        lsu_ack,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idexe_en,
  output logic        exelsu_en,
  output logic        ifid_flush,
  output logic        idexe_flush,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [31:0] stall_count_q;
  logic [15:0] flush_count_q;

  logic load_use;
  logic mem_wait;
  logic run_eval;
  logic last_cycle;
  logic flush_take;

  // Hazard terms. Register x0 never creates a dependency, so a load that
  // targets x0 must not stall.
  assign load_use = exe_is_load & exe_reg_wr & (exe_wr_addr != 5'd0) &
                    ((id_rs1_used & (id_rs1_addr == exe_wr_addr)) |
                     (id_rs2_used & (id_rs2_addr == exe_wr_addr)));
  assign mem_wait = lsu_req & ~lsu_ack;

  // Next-state and output decode. The RUN priority chain (mispredict,
  // load-use, fetch wait, normal) is shared by RUN and by the ack cycle of
  // MEM_WAIT. run_eval selects it, so a mispredict held during a memory wait
  // is taken once the wait completes. The down-counter holds the remaining
  // extra cycles. A multi-cycle state therefore leaves when the counter is
  // about to reach zero. The entry cycle in RUN counts as the first cycle.
  // Reset is applied last so that it overrides every output.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idexe_en    = 1'b0;
    exelsu_en   = 1'b0;
    ifid_flush  = 1'b0;
    idexe_flush = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_take  = 1'b0;
    run_eval    = 1'b0;
    last_cycle  = (cnt_q <= 4'd1);

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      LOAD_STALL: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          cnt_d   = 4'd0;
        end else begin
          idexe_en    = 1'b1;
          idexe_flush = 1'b1;
          exelsu_en   = 1'b1;
          cnt_d       = last_cycle ? 4'd0 : cnt_q - 4'd1;
          if (last_cycle) begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (lsu_ack) begin
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          cnt_d   = 4'd0;
        end else begin
          pc_en      = imem_ready;
          ifid_en    = 1'b1;
          idexe_en   = 1'b1;
          exelsu_en  = 1'b1;
          ifid_flush = 1'b1;
          cnt_d      = last_cycle ? 4'd0 : cnt_q - 4'd1;
          if (last_cycle) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (run_eval) begin
      if (br_mispredict) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idexe_en    = 1'b1;
        exelsu_en   = 1'b1;
        ifid_flush  = 1'b1;
        idexe_flush = 1'b1;
        flush_take  = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_d = RUN;
        end
      end else if (load_use) begin
        idexe_en    = 1'b1;
        idexe_flush = 1'b1;
        exelsu_en   = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d = LOAD_STALL;
          cnt_d   = 4'(LOAD_LAT - 1);
        end else begin
          state_d = RUN;
        end
      end else if (!imem_ready) begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idexe_en   = 1'b1;
        exelsu_en  = 1'b1;
      end else begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idexe_en  = 1'b1;
        exelsu_en = 1'b1;
      end
    end

    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idexe_en    = 1'b0;
      exelsu_en   = 1'b0;
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
      flush_take  = 1'b0;
    end
  end

  // State, down-counter and perf counters. Reset drops any stall, flush or
  // wait in progress. Both counters stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= 32'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (flush_take && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign ctrl_state  = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Drives three instances of pipe_stall_ctrl in parallel. They share inputs
// and use different LOAD_LAT/FLUSH_CYCLES settings. Each instance is compared
// every cycle against a reference model. The model tracks "remaining stall
// cycles", "remaining flush cycles" and "waiting on memory", and derives the
// expected enables, state code and counters from those.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] exe_wr_addr;
  logic       exe_reg_wr;
  logic       exe_is_load;
  logic       br_mispredict;
  logic       lsu_req;
  logic       lsu_ack;
  logic       imem_ready;

  logic [2:0] pc_en_v;
  logic [2:0] ifid_en_v;
  logic [2:0] idexe_en_v;
  logic [2:0] exelsu_en_v;
  logic [2:0] ifid_flush_v;
  logic [2:0] idexe_flush_v;
  logic [1:0]  state_v [3];
  logic [31:0] stall_v [3];
  logic [15:0] flush_v [3];

  int num_vectors = 0;
  int num_miscompares = 0;

  // Reference model state, one entry per instance.
  int     lat_tab [3] = '{1, 3, 4};
  int     fc_tab  [3] = '{1, 2, 3};
  int     ld_left [3];
  int     fl_left [3];
  bit     waiting [3];
  longint stall_cnt [3];
  longint flush_cnt [3];
  bit     regs_known;

  // Free-running clock, posedge at 5, 15, 25, ...
  always #5 clk = ~clk;

  pipe_stall_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1)) u0 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_wr_addr(exe_wr_addr), .exe_reg_wr(exe_reg_wr), .exe_is_load(exe_is_load),
    .br_mispredict(br_mispredict), .lsu_req(lsu_req), .lsu_ack(lsu_ack),
    .imem_ready(imem_ready),
    .pc_en(pc_en_v[0]), .ifid_en(ifid_en_v[0]), .idexe_en(idexe_en_v[0]),
    .exelsu_en(exelsu_en_v[0]), .ifid_flush(ifid_flush_v[0]),
    .idexe_flush(idexe_flush_v[0]), .ctrl_state(state_v[0]),
    .stall_count(stall_v[0]), .flush_count(flush_v[0])
  );

  pipe_stall_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) u1 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_wr_addr(exe_wr_addr), .exe_reg_wr(exe_reg_wr), .exe_is_load(exe_is_load),
    .br_mispredict(br_mispredict), .lsu_req(lsu_req), .lsu_ack(lsu_ack),
    .imem_ready(imem_ready),
    .pc_en(pc_en_v[1]), .ifid_en(ifid_en_v[1]), .idexe_en(idexe_en_v[1]),
    .exelsu_en(exelsu_en_v[1]), .ifid_flush(ifid_flush_v[1]),
    .idexe_flush(idexe_flush_v[1]), .ctrl_state(state_v[1]),
    .stall_count(stall_v[1]), .flush_count(flush_v[1])
  );

  pipe_stall_ctrl #(.LOAD_LAT(4), .FLUSH_CYCLES(3)) u2 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .exe_wr_addr(exe_wr_addr), .exe_reg_wr(exe_reg_wr), .exe_is_load(exe_is_load),
    .br_mispredict(br_mispredict), .lsu_req(lsu_req), .lsu_ack(lsu_ack),
    .imem_ready(imem_ready),
    .pc_en(pc_en_v[2]), .ifid_en(ifid_en_v[2]), .idexe_en(idexe_en_v[2]),
    .exelsu_en(exelsu_en_v[2]), .ifid_flush(ifid_flush_v[2]),
    .idexe_flush(idexe_flush_v[2]), .ctrl_state(state_v[2]),
    .stall_count(stall_v[2]), .flush_count(flush_v[2])
  );

  // Single comparison point: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compares one instance against the model, then advances the model across
  // the coming clock edge. Enables are packed as
  // {pc, ifid, idexe, exelsu, ifid_flush, idexe_flush}.
  task automatic model_step(input int i);
    logic [5:0] exp_outs;
    logic [5:0] obs_outs;
    logic [1:0] exp_state;
    bit lu;
    bit mw;
    lu = exe_is_load && exe_reg_wr && (exe_wr_addr != 0) &&
         ((id_rs1_used && id_rs1_addr == exe_wr_addr) ||
          (id_rs2_used && id_rs2_addr == exe_wr_addr));
    mw = lsu_req && !lsu_ack;

    if (regs_known) begin
      exp_state = waiting[i] ? 2'd2 : (ld_left[i] > 0) ? 2'd1 :
                  (fl_left[i] > 0) ? 2'd3 : 2'd0;
      checkOutput($sformatf("state[%0d]", i), 64'(state_v[i]), 64'(exp_state));
      checkOutput($sformatf("stall_count[%0d]", i), 64'(stall_v[i]), stall_cnt[i]);
      checkOutput($sformatf("flush_count[%0d]", i), 64'(flush_v[i]), flush_cnt[i]);
    end

    if (rst) begin
      exp_outs = 6'b000011;
    end else if (waiting[i] && !lsu_ack) begin
      exp_outs = 6'b000000;
    end else if (!waiting[i] && mw) begin
      exp_outs   = 6'b000000;
      waiting[i] = 1'b1;
      ld_left[i] = 0;
      fl_left[i] = 0;
    end else if (ld_left[i] > 0) begin
      exp_outs = 6'b001101;
      ld_left[i]--;
    end else if (fl_left[i] > 0) begin
      exp_outs = {imem_ready, 5'b11110};
      fl_left[i]--;
    end else begin
      waiting[i] = 1'b0;
      if (br_mispredict) begin
        exp_outs = 6'b111111;
        if (flush_cnt[i] < 64'hFFFF) flush_cnt[i]++;
        fl_left[i] = fc_tab[i] - 1;
      end else if (lu) begin
        exp_outs   = 6'b001101;
        ld_left[i] = lat_tab[i] - 1;
      end else if (!imem_ready) begin
        exp_outs = 6'b011110;
      end else begin
        exp_outs = 6'b111100;
      end
    end

    obs_outs = {pc_en_v[i], ifid_en_v[i], idexe_en_v[i], exelsu_en_v[i],
                ifid_flush_v[i], idexe_flush_v[i]};
    checkOutput($sformatf("outs[%0d]", i), 64'(obs_outs), 64'(exp_outs));

    if (rst) begin
      waiting[i]   = 1'b0;
      ld_left[i]   = 0;
      fl_left[i]   = 0;
      stall_cnt[i] = 0;
      flush_cnt[i] = 0;
    end else if (!exp_outs[5] && stall_cnt[i] < 64'hFFFF_FFFF) begin
      stall_cnt[i]++;
    end
  endtask

  // Applies the current input values for one clock cycle. Outputs are
  // sampled on the falling edge, and the task returns 1 ns after the next
  // rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    if (rst) regs_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst           = 1'b0;
    id_rs1_addr   = 5'd0;
    id_rs2_addr   = 5'd0;
    id_rs1_used   = 1'b0;
    id_rs2_used   = 1'b0;
    exe_wr_addr   = 5'd0;
    exe_reg_wr    = 1'b0;
    exe_is_load   = 1'b0;
    br_mispredict = 1'b0;
    lsu_req       = 1'b0;
    lsu_ack       = 1'b0;
    imem_ready    = 1'b1;
  endtask

  task automatic set_random();
    rst           = ($urandom % 64) == 0;
    id_rs1_addr   = 5'($urandom_range(0, 3));
    id_rs2_addr   = 5'($urandom_range(0, 3));
    id_rs1_used   = 1'($urandom);
    id_rs2_used   = 1'($urandom);
    exe_wr_addr   = 5'($urandom_range(0, 3));
    exe_reg_wr    = ($urandom % 4) != 0;
    exe_is_load   = 1'($urandom);
    br_mispredict = ($urandom % 8) == 0;
    lsu_req       = ($urandom % 4) == 0;
    lsu_ack       = 1'($urandom);
    imem_ready    = ($urandom % 8) != 0;
  endtask

  // Sets up the load-use hazard from the directed test plan:
  // a load into register 5 that the ID instruction reads via rs2.
  task automatic set_load_use(input logic [4:0] wr);
    set_idle();
    exe_is_load = 1'b1;
    exe_reg_wr  = 1'b1;
    exe_wr_addr = wr;
    id_rs2_addr = 5'd5;
    id_rs2_used = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      set_idle();
      applyStimulus();
    end
  endtask

  initial begin
    regs_known = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_left[i] = 0; fl_left[i] = 0; waiting[i] = 1'b0;
      stall_cnt[i] = 0; flush_cnt[i] = 0;
    end
    set_idle();
    rst = 1'b1;
    #1;

    // Reset held for three cycles while the other inputs are random.
    for (int k = 0; k < 3; k++) begin
      set_random();
      rst = 1'b1;
      applyStimulus();
    end
    idle_cycles(2);

    // Single load-use pulse, then the same hazard on x0, which must not stall.
    set_load_use(5'd5); applyStimulus();
    idle_cycles(5);
    set_load_use(5'd0); applyStimulus();
    idle_cycles(2);

    // Mispredict in the same cycle as a load-use: the flush takes priority.
    set_load_use(5'd5); br_mispredict = 1'b1; applyStimulus();
    idle_cycles(4);

    // Memory wait of four cycles while a mispredict is held, then the ack.
    for (int k = 0; k < 4; k++) begin
      set_idle(); lsu_req = 1'b1; br_mispredict = 1'b1; applyStimulus();
    end
    set_idle(); lsu_req = 1'b1; lsu_ack = 1'b1; br_mispredict = 1'b1; applyStimulus();
    idle_cycles(4);

    // Fetch wait.
    set_idle(); imem_ready = 1'b0; applyStimulus();
    idle_cycles(1);

    // Reset arriving in the second cycle of a load stall.
    set_load_use(5'd5); applyStimulus();
    set_idle(); rst = 1'b1; applyStimulus();
    idle_cycles(3);

    // Saturation: preload both counters just below all-ones, then produce
    // several stall cycles and several accepted mispredicts.
    force u0.stall_count_q = 32'hFFFF_FFFE;
    force u1.stall_count_q = 32'hFFFF_FFFE;
    force u2.stall_count_q = 32'hFFFF_FFFE;
    force u0.flush_count_q = 16'hFFFE;
    force u1.flush_count_q = 16'hFFFE;
    force u2.flush_count_q = 16'hFFFE;
    #1;
    release u0.stall_count_q;
    release u1.stall_count_q;
    release u2.stall_count_q;
    release u0.flush_count_q;
    release u1.flush_count_q;
    release u2.flush_count_q;
    for (int i = 0; i < 3; i++) begin
      stall_cnt[i] = 64'hFFFF_FFFE;
      flush_cnt[i] = 64'hFFFE;
    end
    for (int k = 0; k < 3; k++) begin
      set_load_use(5'd5); applyStimulus();
      idle_cycles(4);
    end
    for (int k = 0; k < 3; k++) begin
      set_idle(); br_mispredict = 1'b1; applyStimulus();
      idle_cycles(3);
    end

    // Randomized traffic with occasional resets.
    set_idle(); rst = 1'b1; applyStimulus();
    for (int k = 0; k < 3000; k++) begin
      set_random();
      applyStimulus();
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
